// File: rtl/shader_data_pkg.sv
// Shared types and helpers for the shader operand path.
package shader_data_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_LANES = 4;

  typedef enum logic {
    MODE_VEC          = 1'b0,
    MODE_SCALAR_BCAST = 1'b1
  } op_mode_e;

  // Bit offset of a lane inside a packed vector operand.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/shader_operand_pack.sv
// Normalises scalar or vector operands into lane-masked vector form.
module shader_operand_pack
  import shader_data_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES
) (
  input  op_mode_e                 mode,
  input  logic [LANES-1:0]         lane_mask,
  input  logic [WIDTH-1:0]         a_s,
  input  logic [WIDTH-1:0]         b_s,
  input  logic [WIDTH-1:0]         c_s,
  input  logic [WIDTH*LANES-1:0]   a_v,
  input  logic [WIDTH*LANES-1:0]   b_v,
  input  logic [WIDTH*LANES-1:0]   c_v,
  output logic [WIDTH*LANES-1:0]   a_n_c,
  output logic [WIDTH*LANES-1:0]   b_n_c,
  output logic [WIDTH*LANES-1:0]   c_n_c
);

  // Inactive lanes stay at the zero default.
  always_comb begin
    a_n_c = '0;
    b_n_c = '0;
    c_n_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_mask[i]) begin
        if (mode == MODE_SCALAR_BCAST) begin
          a_n_c[lane_lsb(i, WIDTH) +: WIDTH] = a_s;
          b_n_c[lane_lsb(i, WIDTH) +: WIDTH] = b_s;
          c_n_c[lane_lsb(i, WIDTH) +: WIDTH] = c_s;
        end else begin
          a_n_c[lane_lsb(i, WIDTH) +: WIDTH] = a_v[lane_lsb(i, WIDTH) +: WIDTH];
          b_n_c[lane_lsb(i, WIDTH) +: WIDTH] = b_v[lane_lsb(i, WIDTH) +: WIDTH];
          c_n_c[lane_lsb(i, WIDTH) +: WIDTH] = c_v[lane_lsb(i, WIDTH) +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/shader_operand_queue.sv
// DEPTH-entry first-word fall-through operand queue with enqueue-side normalisation.
module shader_operand_queue
  import shader_data_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned LANES        = DEF_LANES,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [LANES-1:0]             in_lane_mask,
  input  logic [WIDTH-1:0]             in_a_s,
  input  logic [WIDTH-1:0]             in_b_s,
  input  logic [WIDTH-1:0]             in_c_s,
  input  logic [WIDTH*LANES-1:0]       in_a_v,
  input  logic [WIDTH*LANES-1:0]       in_b_v,
  input  logic [WIDTH*LANES-1:0]       in_c_v,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_mode,
  output logic [LANES-1:0]             out_lane_mask,
  output logic [WIDTH*LANES-1:0]       out_a_v,
  output logic [WIDTH*LANES-1:0]       out_b_v,
  output logic [WIDTH*LANES-1:0]       out_c_v,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         in_afull
);

  localparam int unsigned VEC_W   = WIDTH * LANES;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 3 * VEC_W + LANES + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [VEC_W-1:0]   a_n, b_n, c_n;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  logic               full, push, pop;

  shader_operand_pack #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_pack (
    .mode      (op_mode_e'(in_mode)),
    .lane_mask (in_lane_mask),
    .a_s       (in_a_s),
    .b_s       (in_b_s),
    .c_s       (in_c_s),
    .a_v       (in_a_v),
    .b_v       (in_b_v),
    .c_v       (in_c_v),
    .a_n_c     (a_n),
    .b_n_c     (b_n),
    .c_n_c     (c_n)
  );

  // in_ready deliberately ignores out_ready: no pass-through when full.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = !full && !flush && !rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush && !rst;
  assign occupancy = count_q;
  assign in_afull  = (count_q >= CNT_W'(AFULL_THRESH));

  assign wr_entry      = {in_mode, in_lane_mask, a_n, b_n, c_n};
  assign rd_entry      = mem_q[rd_ptr_q];
  assign out_mode      = rd_entry[ENTRY_W-1];
  assign out_lane_mask = rd_entry[3*VEC_W +: LANES];
  assign out_a_v       = rd_entry[2*VEC_W +: VEC_W];
  assign out_b_v       = rd_entry[VEC_W +: VEC_W];
  assign out_c_v       = rd_entry[0 +: VEC_W];

  // Pointer and occupancy next-state; flush drops any same-cycle handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: doc/shader_operand_queue.md
Name: shader_operand_queue

Overview:
Parametrised successor of the shader operand channel. It is a DEPTH-entry valid/ready operand queue between the operand producer and the shader ALU consumer. It carries three operands (A, B, C for MAC) per entry, adds a per-entry mode and lane mask, and normalises every entry to vector form at enqueue: scalar operands are broadcast to all lanes, and masked-off lanes are zeroed. It also provides occupancy, almost-full and a synchronous flush.

Parameters:
WIDTH, 32, bits per lane / per scalar operand
LANES, 4, lanes per vector operand; VEC_W = WIDTH*LANES
DEPTH, 4, queue entries; power of two, >= 2
AFULL_THRESH, DEPTH-1, occupancy at or above which in_afull asserts; 1..DEPTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous queue clear
in_valid  in  1  producer entry valid
in_ready  out  1  queue can accept an entry
in_mode  in  1  0 = MODE_VEC, 1 = MODE_SCALAR_BCAST
in_lane_mask  in  LANES  1 = lane active
in_a_s / in_b_s / in_c_s  in  WIDTH  scalar operands (used when in_mode=1)
in_a_v / in_b_v / in_c_v  in  VEC_W  packed vector operands, lane i at [i*WIDTH +: WIDTH] (used when in_mode=0)
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_mode  out  1  mode of head entry
out_lane_mask  out  LANES  lane mask of head entry
out_a_v / out_b_v / out_c_v  out  VEC_W  normalised vector operands of head
occupancy  out  $clog2(DEPTH+1)  current entry count
in_afull  out  1  occupancy >= AFULL_THRESH

Behaviour:
- Clock is clk; reset is synchronous and active-high, named rst. All state updates occur on the posedge of clk.
- Reset (rst=1 at an edge): write and read pointers = 0, occupancy = 0, out_valid = 0, in_afull = 0. in_ready = 0 while rst is high and 1 in the first cycle after. The data payload is not reset, and out_* data is don't-care while out_valid = 0.
- Reset mid-operation discards all entries. No handshake completes on a cycle where rst = 1.
- Push occurs when in_valid & in_ready & !flush & !rst. Pop occurs when out_valid & out_ready & !flush & !rst.
- in_ready = !full & !flush & !rst. It must not depend on out_ready: there is no bypass when full.
- out_valid = (occupancy != 0). Output is first-word fall-through from storage at the read pointer.
- Latency: an entry pushed at edge N presents on out_* in cycle N+1, which is the minimum. Output data does not change while out_valid & !out_ready.
- Simultaneous push and pop: both take effect and occupancy is unchanged. Pop when full frees a slot, but in_ready is only seen high in the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full is signalled when occupancy == DEPTH.
- flush: pointers and occupancy go to 0 at the edge. Any push or pop presented in the same cycle is ignored. The rst rule has priority over flush.
- Normalisation, applied at enqueue and combinational from the in_* ports:
  - When MODE_SCALAR_BCAST, lane i of A = in_a_s, and likewise for B and C.
  - When MODE_VEC, lane i = the corresponding slice of in_*_v.
  - Then lane i of all three operands is forced to 0 where in_lane_mask[i] = 0.
  - mode and lane mask are stored unchanged.
- Lane mask all-zero is legal; the entry is queued with zero operands.
- in_afull is registered-equivalent from occupancy: combinational from occupancy, which is itself a register.
- The producer must hold in_* stable while in_valid & !in_ready. The queue does not check this.

Decomposition:
- Package shader_data_pkg holds:
  - typedef enum logic {MODE_VEC, MODE_SCALAR_BCAST} op_mode_e
  - lane-slice helper function
  - default WIDTH/LANES constants
- Sub-module shader_operand_pack is combinational. It takes mode, mask, scalar and vector operands and returns the normalised VEC_W operands. It is instantiated once on the enqueue path.
- Storage is a flat array of DEPTH x (3*VEC_W + LANES + 1) bits inside the top.

Test Plan:
1. Reset then single vector push: WIDTH=32, LANES=4, DEPTH=4; in_a_v = {32'h4,32'h3,32'h2,32'h1}, mask 4'hF -> out_valid=1 the next cycle with out_a_v identical, occupancy=1; pop -> out_valid=0, occupancy=0.
2. Scalar broadcast with mask: in_mode=1, in_a_s=32'hDEADBEEF, mask 4'b0101 -> out_a_v = {32'h0,32'hDEADBEEF,32'h0,32'hDEADBEEF}, out_mode=1.
3. Fill and backpressure: out_ready=0, push 4 entries -> in_ready=0, occupancy=4, in_afull=1 from occupancy 3. A 5th in_valid is not accepted. Then drain 4 entries in order 0..3 with wrap, and in_ready=1 after the first pop.
4. Simultaneous push/pop at occupancy 2 for 6 cycles -> occupancy stays 2, FIFO order preserved across pointer wrap.
5. Flush with push in the same cycle at occupancy 3 -> next cycle occupancy=0, out_valid=0, and the pushed entry is not present.
6. rst asserted with occupancy 3 during a held out_valid -> next cycle occupancy=0, out_valid=0, in_ready=0 while rst=1; normal push works after rst falls.
